fft16_pair_reader: RTL and testbench
====================================

Name: fft16_pair_reader

Overview:
Read-side counterpart of the butterfly pair-write register. Holds one 16-point complex frame. Loaded serially, one sample per cycle, then emits the 8 butterfly operand pairs of a selected radix-2 DIT stage over a valid/ready handshake, together with the pair addresses and twiddle index. Sits between the sample source (or the previous stage's write-back) and the butterfly/pair-register datapath of the 16-point FFT.

Parameters:
WORD_SIZE, 16, width of each real and each imaginary component (two's complement, passed through unmodified)

Ports:
clk  input  1  clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  load sample present
load_ready  output  1  block accepts a load sample this cycle
load_re  input  WORD_SIZE  load sample, real part
load_im  input  WORD_SIZE  load sample, imaginary part
flush  input  1  discard the frame and return to EMPTY (honoured only in FULL)
start  input  1  begin emitting the stage given by stage (honoured only in FULL)
stage  input  2  stage 0..3, sampled when start is accepted
pair_valid  output  1  pair outputs valid
pair_ready  input  1  consumer takes the pair
out0_re, out0_im, out1_re, out1_im  output  WORD_SIZE each  upper and lower butterfly operands
idx0, idx1  output  4 each  buffer addresses of out0 and out1
tw_k  output  3  twiddle index k for W16^k
last  output  1  high with the 8th pair of a stage
busy  output  1  high in LOAD or EMIT
done  output  1  one-cycle pulse after the 8th pair transfers

Behaviour:
- Reset (async, rst_n=0): state EMPTY, load counter 0, pair counter 0.
  - All outputs 0 except load_ready=1.
  - Buffer contents undefined; no reset of storage required.
- States: EMPTY, LOAD, FULL, EMIT.
- load_ready=1 in EMPTY and LOAD, 0 otherwise.
- A load transfer occurs when load_valid && load_ready.
  - The sample is written to the address given by the 4-bit load counter, which then increments.
  - First transfer: EMPTY->LOAD.
  - Transfer with counter==15: counter wraps to 0, state ->FULL. busy drops the next cycle.
- FULL:
  - start=1: latch stage, pair counter p=0, ->EMIT.
  - flush=1 with start=0: ->EMPTY.
  - start and flush both high: start wins, flush ignored.
  - flush is ignored in every state other than FULL.
- EMIT, pair addressing for latched stage s and counter p (0..7):
  - h = 1<<s; j = p & (h-1); g = p >> s.
  - idx0 = g*2h + j; idx1 = idx0 + h; tw_k = j << (3-s).
  - out0/out1 are buffer[idx0] and buffer[idx1].
- EMIT timing and handshake:
  - All pair outputs are registered. pair_valid rises in the cycle after start is accepted (latency 1).
  - While pair_valid=1 and pair_ready=0, all pair outputs hold stable.
  - On transfer (pair_valid && pair_ready), p increments and the next pair is presented the following cycle. Back-to-back transfers at one pair per clock are supported.
  - last=1 exactly while p==7 is presented.
  - Transfer with p==7: pair_valid=0 next cycle, done=1 for one cycle, state ->FULL. The frame is retained, so another stage may be started.
- start, flush and load_valid arriving in states where they are not honoured have no effect.
- rst_n asserted mid-LOAD or mid-EMIT: immediate return to reset values. Partial frame discarded; no done pulse.
- The buffer is never written during EMIT. Write-back from the butterfly is outside this block.

Optional Feature:
FFT16_BITREV_LOAD_EN
- Defined: load write address = bit-reverse of the load counter (sample n stored at rev4(n)), so the buffer is ready for DIT stage 0.
- Undefined: natural order, sample n stored at address n.
- Emission addressing is identical in both builds.

Test Plan:
- Reset then load samples re=n, im=-n for n=0..15 back-to-back -> load_ready low after the 16th; busy falls; state FULL; done=0.
- Natural-order build, start with stage=0, pair_ready=1 constant -> 8 consecutive pairs (0,1),(2,3)..(14,15); tw_k=0; out0_re=idx0, out1_re=idx1; last on the 8th; done pulse next cycle.
- stage=3 with pair_ready toggling 1,0 -> pairs (p,p+8), tw_k=p; outputs held during ready-low cycles; exactly 8 transfers. stage=1 -> pairs (0,2),(1,3),(4,6)..; tw_k sequence 0,4,0,4,...
- FFT16_BITREV_LOAD_EN defined, same load, stage=0 -> pair 0 gives out0_re=0, out1_re=8; pair 1 gives 4,12.
- rst_n pulsed low after the 3rd pair of stage 2 -> all outputs 0 immediately, load_ready=1; reload and restart produce the full 8-pair sequence.
- In FULL, start and flush together -> EMIT entered and the frame is kept. flush alone -> EMPTY, load_ready=1.

Source files
------------

// File: rtl/fft16_pair_reader.sv
// 16-point complex frame buffer: serial load, then emits the 8 radix-2 DIT butterfly pairs of one stage.
// Latency: pair outputs registered; first pair valid 1 cycle after start accepted, one pair per clock.
// Backpressure: load_ready low outside EMPTY/LOAD; pair outputs hold while pair_valid && !pair_ready.
// Build option FFT16_BITREV_LOAD_EN: samples stored at bit-reversed addresses during load.
module fft16_pair_reader #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [WORD_SIZE-1:0] load_re,
  input  logic [WORD_SIZE-1:0] load_im,
  input  logic                 flush,
  input  logic                 start,
  input  logic [1:0]           stage,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic [WORD_SIZE-1:0] out0_re,
  output logic [WORD_SIZE-1:0] out0_im,
  output logic [WORD_SIZE-1:0] out1_re,
  output logic [WORD_SIZE-1:0] out1_im,
  output logic [3:0]           idx0,
  output logic [3:0]           idx1,
  output logic [2:0]           tw_k,
  output logic                 last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_FULL, S_EMIT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Frame storage, deliberately not reset
  logic [WORD_SIZE-1:0] r_buf_re [16];
  logic [WORD_SIZE-1:0] r_buf_im [16];

  logic [3:0]           r_load_cnt;
  logic [2:0]           r_pair_cnt;
  logic [1:0]           r_stage;
  logic                 r_pair_valid;
  logic [WORD_SIZE-1:0] r_out0_re;
  logic [WORD_SIZE-1:0] r_out0_im;
  logic [WORD_SIZE-1:0] r_out1_re;
  logic [WORD_SIZE-1:0] r_out1_im;
  logic [3:0]           r_idx0;
  logic [3:0]           r_idx1;
  logic [2:0]           r_tw_k;
  logic                 r_last;
  logic                 r_done;

  logic       w_load_xfer;
  logic       w_start_acc;
  logic       w_pair_xfer;
  logic       w_final_xfer;
  logic [3:0] w_load_addr;
  logic [1:0] w_sel_stage;
  logic [2:0] w_sel_p;
  logic [2:0] w_mask;
  logic [2:0] w_j;
  logic [2:0] w_g;
  logic [2:0] w_shift;
  logic [3:0] w_h;
  logic [3:0] w_idx0;
  logic [3:0] w_idx1;
  logic [2:0] w_tw_k;

  assign load_ready   = (r_state == S_EMPTY) || (r_state == S_LOAD);
  assign busy         = (r_state == S_LOAD) || (r_state == S_EMIT);
  assign w_load_xfer  = load_valid && load_ready;
  assign w_start_acc  = (r_state == S_FULL) && start;
  assign w_pair_xfer  = (r_state == S_EMIT) && r_pair_valid && pair_ready;
  assign w_final_xfer = w_pair_xfer && (r_pair_cnt == 3'd7);

`ifdef FFT16_BITREV_LOAD_EN
  assign w_load_addr = {r_load_cnt[0], r_load_cnt[1], r_load_cnt[2], r_load_cnt[3]};
`else
  assign w_load_addr = r_load_cnt;
`endif

  // Address of the pair to register next: pair 0 of the requested stage on start,
  // otherwise the successor of the pair currently presented.
  always_comb begin
    w_sel_stage = (r_state == S_FULL) ? stage : r_stage;
    w_sel_p     = (r_state == S_FULL) ? 3'd0 : (r_pair_cnt + 3'd1);
    // mask = h-1 with h = 2^s, built without needing a 4th bit
    w_mask      = ~(3'h7 << w_sel_stage);
    w_j         = w_sel_p & w_mask;
    w_g         = w_sel_p >> w_sel_stage;
    w_shift     = {1'b0, w_sel_stage} + 3'd1;
    w_h         = 4'd1 << w_sel_stage;
    w_idx0      = ({1'b0, w_g} << w_shift) | {1'b0, w_j};
    w_idx1      = w_idx0 + w_h;
    w_tw_k      = w_j << (2'd3 - w_sel_stage);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state: start beats flush in FULL; flush is meaningless elsewhere
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_load_xfer) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_load_xfer && (r_load_cnt == 4'd15)) w_state_nxt = S_FULL;
      S_FULL: begin
        if (start)      w_state_nxt = S_EMIT;
        else if (flush) w_state_nxt = S_EMPTY;
      end
      S_EMIT:  if (w_final_xfer) w_state_nxt = S_FULL;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Sample write port; only reachable in EMPTY/LOAD, so EMIT never disturbs the frame
  always_ff @(posedge clk) begin
    if (w_load_xfer) begin
      r_buf_re[w_load_addr] <= load_re;
      r_buf_im[w_load_addr] <= load_im;
    end
  end

  // Load counter; wraps to 0 on the 16th sample, ready for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_load_cnt <= 4'd0;
    else if (w_load_xfer) r_load_cnt <= r_load_cnt + 4'd1;
  end

  // Pair emission registers: load a new pair on start or on each accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage      <= 2'd0;
      r_pair_cnt   <= 3'd0;
      r_pair_valid <= 1'b0;
      r_out0_re    <= '0;
      r_out0_im    <= '0;
      r_out1_re    <= '0;
      r_out1_im    <= '0;
      r_idx0       <= 4'd0;
      r_idx1       <= 4'd0;
      r_tw_k       <= 3'd0;
      r_last       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_acc || (w_pair_xfer && !w_final_xfer)) begin
        if (w_start_acc) r_stage <= stage;
        r_pair_cnt   <= w_sel_p;
        r_pair_valid <= 1'b1;
        r_out0_re    <= r_buf_re[w_idx0];
        r_out0_im    <= r_buf_im[w_idx0];
        r_out1_re    <= r_buf_re[w_idx1];
        r_out1_im    <= r_buf_im[w_idx1];
        r_idx0       <= w_idx0;
        r_idx1       <= w_idx1;
        r_tw_k       <= w_tw_k;
        r_last       <= (w_sel_p == 3'd7);
      end else if (w_final_xfer) begin
        r_pair_cnt   <= 3'd0;
        r_pair_valid <= 1'b0;
        r_last       <= 1'b0;
        r_done       <= 1'b1;
      end
    end
  end

  assign pair_valid = r_pair_valid;
  assign out0_re    = r_out0_re;
  assign out0_im    = r_out0_im;
  assign out1_re    = r_out1_re;
  assign out1_im    = r_out1_im;
  assign idx0       = r_idx0;
  assign idx1       = r_idx1;
  assign tw_k       = r_tw_k;
  assign last       = r_last;
  assign done       = r_done;

endmodule

// File: tb/tb_fft16_pair_reader.sv
// Bench for fft16_pair_reader: directed and random frames, all four stages,
// ready backpressure patterns, start/flush priority and mid-emission reset.
module tb_fft16_pair_reader;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_re;
  logic [W-1:0] load_im;
  logic         flush;
  logic         start;
  logic [1:0]   stage;
  logic         pair_valid;
  logic         pair_ready;
  logic [W-1:0] out0_re, out0_im, out1_re, out1_im;
  logic [3:0]   idx0, idx1;
  logic [2:0]   tw_k;
  logic         last, busy, done;

  always #5 clk = ~clk;

  fft16_pair_reader #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_re(load_re), .load_im(load_im),
    .flush(flush), .start(start), .stage(stage),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .out0_re(out0_re), .out0_im(out0_im), .out1_re(out1_re), .out1_im(out1_im),
    .idx0(idx0), .idx1(idx1), .tw_k(tw_k),
    .last(last), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame contents by buffer address, and expected pair list
  logic [W-1:0] m_re [16];
  logic [W-1:0] m_im [16];
  typedef struct { int i0; int i1; int tw; } pair_t;
  pair_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int store_addr(input int n);
`ifdef FFT16_BITREV_LOAD_EN
    return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
`else
    return n;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_load_ready"}, load_ready, 1);
    chk({tag, "_pair_valid"}, pair_valid, 0);
    chk({tag, "_outs"}, {out0_re, out0_im}, 0);
    chk({tag, "_outs1"}, {out1_re, out1_im}, 0);
    chk({tag, "_idx_tw"}, {idx0, idx1, tw_k}, 0);
    chk({tag, "_flags"}, {last, busy, done}, 0);
  endtask

  task automatic load_frame(input bit directed, input bit gaps);
    logic [W-1:0] re, im;
    for (int n = 0; n < 16; n++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        load_valid = 1'b0;
        step();
        chk("load_ready_gap", load_ready, 1);
      end
      re = directed ? W'(n) : W'($urandom);
      im = directed ? W'(-n) : W'($urandom);
      chk("load_ready", load_ready, 1);
      load_valid = 1'b1;
      load_re = re;
      load_im = im;
      m_re[store_addr(n)] = re;
      m_im[store_addr(n)] = im;
      step();
      if (n == 0) chk("busy_loading", busy, 1);
    end
    load_valid = 1'b0;
    chk("load_ready_full", load_ready, 0);
    chk("busy_full", busy, 0);
    chk("done_full", done, 0);
    chk("pair_valid_full", pair_valid, 0);
  endtask

  // mode 0: ready always; 1: ready toggles 1,0; 2: random ready
  task automatic run_stage(input int s, input int mode, input bit with_flush, input int abort_after);
    int  h;
    int  xfers;
    bit  rdy;
    h = 1 << s;
    q.delete();
    for (int i = 0; i < 16; i++)
      if ((i & h) == 0) q.push_back('{i, i + h, (i % h) * (8 / h)});
    stage = 2'(s);
    start = 1'b1;
    flush = with_flush;
    step();
    start = 1'b0;
    flush = 1'b0;
    chk("pair_valid_latency", pair_valid, 1);
    chk("busy_emit", busy, 1);
    xfers = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (q.size() == 0) break;
      if ((abort_after > 0) && (xfers == abort_after)) break;
      chk("pair_valid", pair_valid, 1);
      chk("idx0", idx0, q[0].i0);
      chk("idx1", idx1, q[0].i1);
      chk("tw_k", tw_k, q[0].tw);
      chk("out0", {out0_re, out0_im}, {m_re[q[0].i0], m_im[q[0].i0]});
      chk("out1", {out1_re, out1_im}, {m_re[q[0].i1], m_im[q[0].i1]});
      chk("last", last, (q.size() == 1) ? 1 : 0);
      chk("done_during", done, 0);
      chk("load_ready_emit", load_ready, 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      pair_ready = rdy;
      // loads and flushes offered during EMIT must be ignored
      load_valid = 1'($urandom);
      load_re    = W'($urandom);
      load_im    = W'($urandom);
      flush      = 1'($urandom);
      step();
      if (rdy) begin
        void'(q.pop_front());
        xfers++;
      end
    end
    pair_ready = 1'b0;
    load_valid = 1'b0;
    flush      = 1'b0;
    if (abort_after == 0) begin
      chk("pairs_remaining", q.size(), 0);
      chk("xfer_count", xfers, 8);
      chk("pair_valid_end", pair_valid, 0);
      chk("done_pulse", done, 1);
      chk("last_end", last, 0);
      chk("busy_end", busy, 0);
      step();
      chk("done_one_cycle", done, 0);
      chk("load_ready_refull", load_ready, 0);
    end else begin
      chk("abort_xfers", xfers, abort_after);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0; load_re = '0; load_im = '0;
    flush = 1'b0; start = 1'b0; stage = 2'd0; pair_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // start/flush are not honoured in EMPTY
    flush = 1'b1; start = 1'b1;
    step();
    flush = 1'b0; start = 1'b0;
    chk("empty_ignore_ready", load_ready, 1);
    chk("empty_ignore_valid", pair_valid, 0);

    load_frame(1'b1, 1'b0);
    run_stage(0, 0, 1'b0, 0);
    run_stage(3, 1, 1'b0, 0);
    run_stage(1, 2, 1'b0, 0);

    // reset in the middle of stage 2
    run_stage(2, 0, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    step();
    chk_reset_outputs("mid_reset_held");
    rst_n = 1'b1;
    step();

    load_frame(1'b0, 1'b1);
    run_stage(2, 2, 1'b0, 0);
    run_stage(0, 1, 1'b1, 0);   // start and flush together: frame kept
    run_stage(3, 2, 1'b0, 0);

    // flush alone discards the frame
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_load_ready", load_ready, 1);
    chk("flush_busy", busy, 0);
    chk("flush_pair_valid", pair_valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_after_flush", pair_valid, 0);

    load_frame(1'b0, 1'b0);
    run_stage(1, 0, 1'b0, 0);
    run_stage(2, 1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
